mem_access_ctrl: RTL and testbench

- Bus-cycle sequencer between the processor's memory-request signals (mr/mw) and an asynchronous-style memory bus using active-low address strobe, write strobe, stop and acknowledge.
- Latches a one-cycle or held request, drives the strobes until memory acknowledges, then closes the cycle.
- Exposes its state and busy/idle flags so the pipeline can stall.

---
 rtl/mem_access_ctrl_pkg.sv | 14 +
 rtl/mem_access_ctrl_sync_chain.sv | 22 ++
 rtl/mem_access_ctrl.sv | 98 +++++++++
 tb/tb_mem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: state width and the
// bus-cycle state encodings that appear on sm_state.
package mem_access_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_sync_chain.sv
// Single-bit flop chain with a parameterisable depth and reset value.
// Instantiated by mem_access_ctrl only when MAC_ACK_SYNC_EN is defined.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= {STAGES{RESET_VAL}};
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-cycle sequencer: turns mr/mw requests into an as_n/wr_n/stop_n cycle
// closed by ack_n. Define MAC_ACK_SYNC_EN to pass ack_n through a sync chain.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ack_n,
  input  logic               mr,
  input  logic               mw,
  output logic [STATE_W-1:0] sm_state,
  output logic               as_n,
  output logic               stop_n,
  output logic               wr_n,
  output logic               in_init,
  output logic               busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  state_t state;
  state_t next_state;
  logic   wr_flag;
  logic   next_wr_flag;
  logic   ack_eff_n;

`ifdef MAC_ACK_SYNC_EN
  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_n),
    .q     (ack_eff_n)
  );
`else
  assign ack_eff_n = ack_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_flag <= 1'b0;
    end else begin
      state   <= next_state;
      wr_flag <= next_wr_flag;
    end
  end

  // Requests are only looked at in IDLE; write takes priority over read.
  always_comb begin
    next_state   = state;
    next_wr_flag = wr_flag;
    case (state)
      IDLE: begin
        if (mw) begin
          next_state   = START;
          next_wr_flag = 1'b1;
        end else if (mr) begin
          next_state   = START;
          next_wr_flag = 1'b0;
        end
      end
      START:   next_state = WAIT;
      WAIT:    if (!ack_eff_n) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    as_n    = 1'b1;
    wr_n    = 1'b1;
    stop_n  = 1'b1;
    in_init = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        in_init = 1'b1;
        busy    = 1'b0;
      end
      START, WAIT: begin
        as_n = 1'b0;
        wr_n = !wr_flag;
      end
      DONE:    stop_n = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  assign sm_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default or MAC_ACK_SYNC_EN build).
module tb_mem_access_ctrl;

`ifdef MAC_ACK_SYNC_EN
  localparam int ACK_EXTRA = 2;
`else
  localparam int ACK_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ack_n;
  logic       mr;
  logic       mw;
  logic [1:0] sm_state;
  logic       as_n;
  logic       stop_n;
  logic       wr_n;
  logic       in_init;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .ack_n    (ack_n),
    .mr       (mr),
    .mw       (mw),
    .sm_state (sm_state),
    .as_n     (as_n),
    .stop_n   (stop_n),
    .wr_n     (wr_n),
    .in_init  (in_init),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until DONE with ack held low; reports cycle count (-1 on timeout)
  // and whether the WAIT strobes stayed correct on the way.
  task automatic run_to_done(input logic exp_wr_n, output int n, output bit strobes_ok);
    n = 0;
    strobes_ok = 1'b1;
    while (sm_state !== 2'b11 && n < 40) begin
      tick();
      n++;
      if (sm_state === 2'b10 && (as_n !== 1'b0 || wr_n !== exp_wr_n || stop_n !== 1'b1))
        strobes_ok = 1'b0;
    end
    if (sm_state !== 2'b11) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_n = 1'b1; mr = 1'b0; mw = 1'b0;
    tick();
    tick();
    checks++;
    if ({sm_state, as_n, wr_n, stop_n, in_init, busy} !== 7'b00_1111_0) begin
      $display("FAIL reset_state: got st=%b as=%b wr=%b stop=%b init=%b busy=%b want st=00 as=1 wr=1 stop=1 init=1 busy=0",
               sm_state, as_n, wr_n, stop_n, in_init, busy);
      errors++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_pulse();
    int  n;
    bit  ok;
    mw = 1'b1;
    tick();
    mw = 1'b0;
    checks++;
    if ({sm_state, as_n, wr_n, stop_n, in_init, busy} !== 7'b01_0010_1) begin
      $display("FAIL wr_start: got st=%b as=%b wr=%b stop=%b init=%b busy=%b want st=01 as=0 wr=0 stop=1 init=0 busy=1",
               sm_state, as_n, wr_n, stop_n, in_init, busy);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sm_state, as_n, wr_n, stop_n, busy} !== 6'b10_0011) begin
        $display("FAIL wr_wait%0d: got st=%b as=%b wr=%b stop=%b busy=%b want st=10 as=0 wr=0 stop=1 busy=1",
                 i, sm_state, as_n, wr_n, stop_n, busy);
        errors++;
      end
    end
    ack_n = 1'b0;
    run_to_done(1'b0, n, ok);
    ack_n = 1'b1;
    checks++;
    if (n !== 1 + ACK_EXTRA || !ok) begin
      $display("FAIL wr_ack_latency: got %0d cycles strobes_ok=%0d want %0d cycles strobes_ok=1", n, ok, 1 + ACK_EXTRA);
      errors++;
    end
    checks++;
    if ({as_n, wr_n, stop_n, in_init, busy} !== 5'b11001) begin
      $display("FAIL wr_done: got as=%b wr=%b stop=%b init=%b busy=%b want as=1 wr=1 stop=0 init=0 busy=1",
               as_n, wr_n, stop_n, in_init, busy);
      errors++;
    end
    tick();
    checks++;
    if ({sm_state, as_n, wr_n, stop_n, in_init, busy} !== 7'b00_1111_0) begin
      $display("FAIL wr_idle: got st=%b as=%b wr=%b stop=%b init=%b busy=%b want st=00 as=1 wr=1 stop=1 init=1 busy=0",
               sm_state, as_n, wr_n, stop_n, in_init, busy);
      errors++;
    end
    repeat (4) tick();
  endtask

  task automatic test_read_held();
    int n;
    bit ok;
    bit wait_ok = 1'b1;
    bit stayed_idle = 1'b1;
    mr = 1'b1;
    tick();
    checks++;
    if ({sm_state, as_n, wr_n} !== 4'b01_01) begin
      $display("FAIL rd_start: got st=%b as=%b wr=%b want st=01 as=0 wr=1", sm_state, as_n, wr_n);
      errors++;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({sm_state, as_n, wr_n, stop_n} !== 5'b10_011) wait_ok = 1'b0;
    end
    checks++;
    if (!wait_ok) begin
      $display("FAIL rd_wait_hold: got strobes_ok=0 want strobes_ok=1 (st=10 as=0 wr=1 stop=1)");
      errors++;
    end
    ack_n = 1'b0;
    run_to_done(1'b1, n, ok);
    ack_n = 1'b1;
    mr = 1'b0;
    checks++;
    if (n !== 1 + ACK_EXTRA || !ok || stop_n !== 1'b0 || wr_n !== 1'b1) begin
      $display("FAIL rd_done: got %0d cycles ok=%0d stop=%b wr=%b want %0d cycles ok=1 stop=0 wr=1",
               n, ok, stop_n, wr_n, 1 + ACK_EXTRA);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sm_state !== 2'b00 || busy !== 1'b0) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle) begin
      $display("FAIL rd_single_txn: got idle_held=0 state=%b want idle_held=1 state=00", sm_state);
      errors++;
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bit ok;
    bit stayed_idle = 1'b1;
    mr = 1'b1;
    mw = 1'b1;
    tick();
    mr = 1'b0;
    mw = 1'b0;
    checks++;
    if ({sm_state, as_n, wr_n} !== 4'b01_00) begin
      $display("FAIL both_start: got st=%b as=%b wr=%b want st=01 as=0 wr=0", sm_state, as_n, wr_n);
      errors++;
    end
    tick();
    ack_n = 1'b0;
    run_to_done(1'b0, n, ok);
    ack_n = 1'b1;
    checks++;
    if (n !== 1 + ACK_EXTRA || !ok) begin
      $display("FAIL both_write_cycle: got %0d cycles ok=%0d want %0d cycles ok=1", n, ok, 1 + ACK_EXTRA);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sm_state !== 2'b00) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle) begin
      $display("FAIL both_no_read: got idle_held=0 state=%b want idle_held=1 state=00", sm_state);
      errors++;
    end
  endtask

  task automatic test_ack_ignored();
    int n;
    bit ok;
    ack_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (sm_state !== 2'b00 || in_init !== 1'b1) begin
      $display("FAIL ack_idle_ignored: got st=%b init=%b want st=00 init=1", sm_state, in_init);
      errors++;
    end
`ifdef MAC_ACK_SYNC_EN
    ack_n = 1'b1;
    repeat (4) tick();
`endif
    mr = 1'b1;
    tick();
    mr = 1'b0;
    tick();
    ack_n = 1'b1;
    checks++;
    if (sm_state !== 2'b10) begin
      $display("FAIL ack_start_ignored: got st=%b want st=10", sm_state);
      errors++;
    end
    repeat (4) tick();
    checks++;
    if (sm_state !== 2'b10 || as_n !== 1'b0) begin
      $display("FAIL ack_wait_fresh: got st=%b as=%b want st=10 as=0", sm_state, as_n);
      errors++;
    end
    ack_n = 1'b0;
    run_to_done(1'b1, n, ok);
    ack_n = 1'b1;
    checks++;
    if (n !== 1 + ACK_EXTRA || !ok) begin
      $display("FAIL ack_fresh_done: got %0d cycles ok=%0d want %0d cycles ok=1", n, ok, 1 + ACK_EXTRA);
      errors++;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    mw = 1'b1;
    tick();
    mw = 1'b0;
    tick();
    tick();
    checks++;
    if (sm_state !== 2'b10 || wr_n !== 1'b0) begin
      $display("FAIL mid_setup: got st=%b wr=%b want st=10 wr=0", sm_state, wr_n);
      errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({sm_state, as_n, wr_n, stop_n, in_init, busy} !== 7'b00_1111_0) begin
      $display("FAIL mid_reset: got st=%b as=%b wr=%b stop=%b init=%b busy=%b want st=00 as=1 wr=1 stop=1 init=1 busy=0",
               sm_state, as_n, wr_n, stop_n, in_init, busy);
      errors++;
    end
    // A read after reset checks that the write flag was cleared with the state.
    mr = 1'b1;
    tick();
    mr = 1'b0;
    checks++;
    if ({sm_state, as_n, wr_n} !== 4'b01_01) begin
      $display("FAIL post_reset_read: got st=%b as=%b wr=%b want st=01 as=0 wr=1", sm_state, as_n, wr_n);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_write_pulse();
    test_read_held();
    test_simultaneous();
    test_ack_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
